// File: rtl/matinv_pkg.sv
// Shared constants, serializer state encoding and flattened-matrix slice helper for the 5x5 inverter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package matinv_pkg;

    localparam int N         = 5;
    localparam int W         = 32;
    localparam int NUM_ELEMS = N * N;
    localparam int IDX_W     = 5;
    localparam int TAG_W     = 3;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } ser_state_t;

    // Element (r,c) of a row-major flattened N x N matrix, zero-based indices.
    function automatic logic [W-1:0] elem_slice(input logic [N*N*W-1:0] mat,
                                                input int r,
                                                input int c);
        return mat[(r * N + c) * W +: W];
    endfunction

endpackage

// File: rtl/matinv_result_serializer.sv
// Captures a 5x5 inverse in one handshake and streams it row-major, one word per out handshake,
// with row/col/last tags. Optional XOR checksum word appended when MATINV_SER_CHECKSUM_EN is defined.
// Latency: first word valid the cycle after capture; backpressure: words hold while out_ready=0, no capture while streaming.
module matinv_result_serializer
    import matinv_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N*N*W-1:0]   in_matrix,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [W-1:0]       out_data,
    output logic [TAG_W-1:0]   out_row,
    output logic [TAG_W-1:0]   out_col,
    output logic               out_last,
    output logic               busy
);

`ifdef MATINV_SER_CHECKSUM_EN
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ELEMS);
`else
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ELEMS - 1);
`endif
    localparam logic [TAG_W-1:0] COL_MAX  = TAG_W'(N - 1);

    ser_state_t         state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [TAG_W-1:0]   row_q, row_d;
    logic [TAG_W-1:0]   col_q, col_d;
    logic               capture;
    logic [W-1:0]       elem_q [NUM_ELEMS];
    logic [W-1:0]       cur_word;

`ifdef MATINV_SER_CHECKSUM_EN
    logic [W-1:0]       chk_q, chk_d;

    // XOR fold of the incoming matrix, registered alongside the elements at capture.
    always_comb begin
        chk_d = '0;
        for (int i = 0; i < NUM_ELEMS; i++) begin
            chk_d = chk_d ^ in_matrix[i*W +: W];
        end
    end

    // Checksum register, refreshed only on capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            chk_q <= '0;
        end else if (capture) begin
            chk_q <= chk_d;
        end
    end
`endif

    // Next-state, word index and row/col tag counters.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        row_d   = row_q;
        col_d   = col_q;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    capture = 1'b1;
                    state_d = STREAM;
                    idx_d   = '0;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            STREAM: begin
                if (out_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = IDLE;
                        idx_d   = '0;
                        row_d   = '0;
                        col_d   = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                        // Wrapping the column after (4,4) lands on row 5, col 0: the checksum tag.
                        if (col_q == COL_MAX) begin
                            col_d = '0;
                            row_d = row_q + TAG_W'(1);
                        end else begin
                            col_d = col_q + TAG_W'(1);
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
                row_d   = '0;
                col_d   = '0;
            end
        endcase
    end

    // State and counter registers; reset aborts any stream in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            row_q   <= row_d;
            col_q   <= col_d;
        end
    end

    // Capture buffer; only written on an accepted input so later in_matrix changes are ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_ELEMS; i++) begin
                elem_q[i] <= '0;
            end
        end else if (capture) begin
            for (int i = 0; i < NUM_ELEMS; i++) begin
                elem_q[i] <= elem_slice(in_matrix, i / N, i % N);
            end
        end
    end

    // Select the word at the current index (checksum sits one past the last element).
    always_comb begin
        cur_word = '0;
        if (idx_q < IDX_W'(NUM_ELEMS)) begin
            cur_word = elem_q[idx_q];
        end
`ifdef MATINV_SER_CHECKSUM_EN
        else if (idx_q == IDX_W'(NUM_ELEMS)) begin
            cur_word = chk_q;
        end
`endif
    end

    // Outputs decode registered state only; nothing combinational from in_valid or out_ready.
    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == STREAM);
    assign out_data  = (state_q == STREAM) ? cur_word : '0;
    assign out_row   = row_q;
    assign out_col   = col_q;
    assign out_last  = (state_q == STREAM) && (idx_q == LAST_IDX);

endmodule

// File: tb/tb_matinv_result_serializer.sv
// Directed bench for the matrix result serializer: reset, streaming, backpressure, ignored input, mid-stream reset, checksum.
// Latency: expects first word one cycle after capture, one word per accepted handshake.
// Backpressure: drives out_ready patterns and checks words hold while stalled.
module tb_matinv_result_serializer;
    import matinv_pkg::*;

`ifdef MATINV_SER_CHECKSUM_EN
    localparam int NW = NUM_ELEMS + 1;
`else
    localparam int NW = NUM_ELEMS;
`endif

    logic               clk = 1'b0;
    logic               reset;
    logic               in_valid;
    logic               in_ready;
    logic [N*N*W-1:0]   in_matrix;
    logic               out_valid;
    logic               out_ready;
    logic [W-1:0]       out_data;
    logic [TAG_W-1:0]   out_row;
    logic [TAG_W-1:0]   out_col;
    logic               out_last;
    logic               busy;

    int checks = 0;
    int errors = 0;

    matinv_result_serializer dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_matrix (in_matrix),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_row   (out_row),
        .out_col   (out_col),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pattern value of element idx: 0 -> 0x100*r+c, 1 -> 0xA5A50000+idx.
    function automatic logic [W-1:0] pat_val(input int pat, input int idx);
        if (pat == 0) return 32'h100 * (idx / N) + (idx % N);
        return 32'hA5A5_0000 + idx;
    endfunction

    // Expected word k of a stream; k == NUM_ELEMS is the XOR checksum.
    function automatic logic [W-1:0] exp_word(input int pat, input int k);
        logic [W-1:0] x;
        if (k < NUM_ELEMS) return pat_val(pat, k);
        x = '0;
        for (int i = 0; i < NUM_ELEMS; i++) x ^= pat_val(pat, i);
        return x;
    endfunction

    // Flatten by shifting so that element 0 ends in the low bits.
    function automatic logic [N*N*W-1:0] build(input int pat);
        logic [N*N*W-1:0] m;
        m = '0;
        for (int i = NUM_ELEMS - 1; i >= 0; i--) m = (m << W) | {{(N*N*W-W){1'b0}}, pat_val(pat, i)};
        return m;
    endfunction

    // Present a matrix for one cycle, starting at a negedge; returns at the next negedge.
    task automatic capture(input int pat);
        chk("cap_in_ready", {31'b0, in_ready}, 32'd1);
        in_matrix = build(pat);
        in_valid  = 1'b1;
        @(negedge clk);
        in_valid  = 1'b0;
    endtask

    // mode 0: ready high; 1: ready 1,0,0,1; 2: ready high plus mid-stream in_valid and matrix change.
    // stop_after > 0 returns after that many words without the end-of-stream checks.
    task automatic stream(input int pat, input int mode, input int stop_after);
        int k;
        int cyc;
        int target;
        logic rdy;
        k = 0;
        cyc = 0;
        target = (stop_after > 0) ? stop_after : NW;
        while (k < target && cyc < 300) begin
            rdy = (mode == 1) ? ((cyc % 4) == 0 || (cyc % 4) == 3) : 1'b1;
            out_ready = rdy;
            chk("vld", {31'b0, out_valid}, 32'd1);
            chk("busy", {31'b0, busy}, 32'd1);
            chk("in_ready_low", {31'b0, in_ready}, 32'd0);
            chk("data", out_data, exp_word(pat, k));
            chk("row", {29'b0, out_row}, k / N);
            chk("col", {29'b0, out_col}, k % N);
            chk("last", {31'b0, out_last}, {31'b0, (k == NW - 1)});
            if (mode == 2 && cyc == 3) begin
                in_valid  = 1'b1;
                in_matrix = ~build(pat);
            end
            if (mode == 2 && cyc == 5) in_valid = 1'b0;
            @(negedge clk);
            cyc++;
            if (rdy) k++;
        end
        chk("stream_timeout", k, target);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        if (stop_after == 0) begin
            chk("end_vld", {31'b0, out_valid}, 32'd0);
            chk("end_in_ready", {31'b0, in_ready}, 32'd1);
            chk("end_busy", {31'b0, busy}, 32'd0);
        end
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_matrix = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset / idle values.
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_data", out_data, 32'd0);
        chk("rst_row", {29'b0, out_row}, 32'd0);
        chk("rst_col", {29'b0, out_col}, 32'd0);
        chk("rst_last", {31'b0, out_last}, 32'd0);

        // Full-rate stream.
        capture(0);
        stream(0, 0, 0);

        // Backpressure 1,0,0,1.
        capture(0);
        stream(0, 1, 0);

        // Input changes and in_valid pulses mid-stream are ignored.
        capture(0);
        stream(0, 2, 0);
        @(negedge clk);
        chk("no_second_capture", {31'b0, out_valid}, 32'd0);

        // Reset after 10 words aborts; fresh capture restarts at (0,0).
        capture(0);
        stream(0, 0, 10);
        reset = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        out_ready = 1'b0;
        chk("abort_out_valid", {31'b0, out_valid}, 32'd0);
        chk("abort_in_ready", {31'b0, in_ready}, 32'd1);
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_data", out_data, 32'd0);
        chk("abort_row", {29'b0, out_row}, 32'd0);
        chk("abort_col", {29'b0, out_col}, 32'd0);
        capture(0);
        stream(0, 0, 0);

        // Second pattern (checksum word appended when the option is built in).
        capture(1);
        stream(1, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
